// File: rtl/uplink_tx_if.sv
// Keycode handshake and AGC uplink pulse lines between a keycode source and uplink_tx.
interface uplink_tx_if;
  localparam int unsigned KEY_W = 5;

  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             key_ready;
  logic             upl0;
  logic             upl1;
  logic             busy;

  modport master (output key, key_valid, input key_ready, upl0, upl1, busy);
  modport slave  (input key, key_valid, output key_ready, upl0, upl1, busy);
endinterface

// File: rtl/uplink_tx.sv
// Ground-side AGC uplink transmitter: serialises a keycode as {c, ~c, c}, MSB first,
// one upl1/upl0 pulse per bit, separated by inter-bit and inter-word gaps.
module uplink_tx #(
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES      = 16,
  parameter int unsigned WORD_GAP_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  uplink_tx_if.slave up
);
  localparam int unsigned WORD_W  = 15;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned PG_MAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CYC_MAX = (PG_MAX > WORD_GAP_CYCLES) ? PG_MAX : WORD_GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WGAP_LOAD  =
    CNT_W'((WORD_GAP_CYCLES == 0) ? 0 : WORD_GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_WGAP  = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [WORD_W-1:0] shift_q,     shift_d;
  logic [BIT_W-1:0]  bit_q,       bit_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              upl0_q,      upl0_d;
  logic              upl1_q,      upl1_d;
  logic              busy_q,      busy_d;
  logic              key_ready_q, key_ready_d;
  logic              accept;

  // The FSM runs one cycle ahead of the registered pulse lines. Its final IDLE
  // cycle coincides with the frame-end edge, so a held key_valid is taken there.
  assign accept = up.key_valid & (state_q == S_IDLE);

  // Next-state, shift and counter logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_PULSE;
          shift_d = {up.key, ~up.key, up.key};
          bit_d   = BIT_W'(WORD_W - 1);
          cnt_d   = PULSE_LOAD;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bit_q != '0) begin
          state_d = S_PULSE;
          shift_d = {shift_q[WORD_W-2:0], 1'b0};
          bit_d   = bit_q - BIT_W'(1);
          cnt_d   = PULSE_LOAD;
        end else if (WORD_GAP_CYCLES == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WGAP;
          cnt_d   = WGAP_LOAD;
        end
      end
      S_WGAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    upl1_d      = (state_q == S_PULSE) &  shift_q[WORD_W-1];
    upl0_d      = (state_q == S_PULSE) & ~shift_q[WORD_W-1];
    busy_d      = (state_q != S_IDLE) | accept;
    key_ready_d = (state_q == S_IDLE) & ~accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      upl0_q      <= 1'b0;
      upl1_q      <= 1'b0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      upl0_q      <= upl0_d;
      upl1_q      <= upl1_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign up.upl0      = upl0_q;
  assign up.upl1      = upl1_q;
  assign up.busy      = busy_q;
  assign up.key_ready = key_ready_q;
endmodule

// File: tb/tb_uplink_tx.sv
// Bench for uplink_tx: default and minimal-timing instances checked every cycle
// against a waveform model derived from the accept edge and keycode.
module tb_uplink_tx;
  localparam int P0 = 4, G0 = 16, W0 = 64;
  localparam int P1 = 1, G1 = 1, W1 = 0;
  localparam int NBITS = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uplink_tx_if if0 ();
  uplink_tx_if if1 ();

  uplink_tx #(.PULSE_CYCLES(P0), .GAP_CYCLES(G0), .WORD_GAP_CYCLES(W0))
    dut0 (.clk(clk), .rst(rst), .up(if0));
  uplink_tx #(.PULSE_CYCLES(P1), .GAP_CYCLES(G1), .WORD_GAP_CYCLES(W1))
    dut1 (.clk(clk), .rst(rst), .up(if1));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit done     = 1'b0;

  // model: last accept edge and key per instance
  int         a_edge    [2] = '{-1, -1};
  logic [4:0] a_key     [2] = '{5'd0, 5'd0};
  int         frame_end [2] = '{0, 0};
  int         acc_cnt   [2] = '{0, 0};

  // observed pulse history
  logic prev_on   [2] = '{1'b0, 1'b0};
  logic prev_rdy  [2] = '{1'b1, 1'b1};
  int   rise_at   [2] = '{0, 0};
  int   last_fall [2] = '{-1, -1};
  int   rdy_rise  [2] = '{0, 0};
  int   rise_q [$];
  logic line_q [$];

  function automatic int plen(input int i); return (i == 0) ? P0 : P1; endfunction
  function automatic int glen(input int i); return (i == 0) ? G0 : G1; endfunction
  function automatic int wlen(input int i); return (i == 0) ? W0 : W1; endfunction
  function automatic int flen(input int i);
    return 1 + NBITS * (plen(i) + glen(i)) + wlen(i);
  endfunction
  function automatic logic [14:0] word_of(input logic [4:0] k); return {k, ~k, k}; endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // expected line levels after the current edge, from accept time and key alone
  task automatic expect_of(input int i, output logic e0, output logic e1,
                           output logic eb, output logic er);
    int t, u, j, per;
    logic [14:0] w;
    e0 = 1'b0; e1 = 1'b0; eb = 1'b0; er = 1'b1;
    per = plen(i) + glen(i);
    if (a_edge[i] >= 0) begin
      t = cyc - a_edge[i];
      if (t < flen(i)) begin
        eb = 1'b1; er = 1'b0;
        if (t >= 1) begin
          u = t - 1;
          j = u / per;
          if (j < NBITS && (u % per) < plen(i)) begin
            w  = word_of(a_key[i]);
            e1 = w[NBITS-1-j];
            e0 = ~w[NBITS-1-j];
          end
        end
      end
    end
  endtask

  task automatic check_dut(input int i, input logic u0, input logic u1,
                           input logic b, input logic r);
    logic e0, e1, eb, er, on;
    expect_of(i, e0, e1, eb, er);
    chk($sformatf("d%0d_upl0", i), 32'(u0), 32'(e0));
    chk($sformatf("d%0d_upl1", i), 32'(u1), 32'(e1));
    chk($sformatf("d%0d_busy", i), 32'(b), 32'(eb));
    chk($sformatf("d%0d_key_ready", i), 32'(r), 32'(er));
    chk($sformatf("d%0d_exclusive", i), 32'(u0 & u1), 32'd0);
    on = u0 | u1;
    if (on && !prev_on[i]) begin
      if (last_fall[i] >= 0)
        chk($sformatf("d%0d_min_gap", i), 32'((cyc - last_fall[i]) >= glen(i)), 32'd1);
      rise_at[i] = cyc;
      if (i == 0) begin rise_q.push_back(cyc); line_q.push_back(u1); end
    end
    if (!on && prev_on[i]) begin
      chk($sformatf("d%0d_width", i), 32'(cyc - rise_at[i]), 32'(plen(i)));
      last_fall[i] = cyc;
    end
    if (r && !prev_rdy[i]) rdy_rise[i] = cyc;
    prev_on[i]  = on;
    prev_rdy[i] = r;
  endtask

  // reference model update on each edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin a_edge[i] = -1; frame_end[i] = 0; end
    end else begin
      if (if0.key_valid === 1'b1 && cyc >= frame_end[0]) begin
        a_edge[0] = cyc; a_key[0] = if0.key; frame_end[0] = cyc + flen(0); acc_cnt[0]++;
      end
      if (if1.key_valid === 1'b1 && cyc >= frame_end[1]) begin
        a_edge[1] = cyc; a_key[1] = if1.key; frame_end[1] = cyc + flen(1); acc_cnt[1]++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        prev_on[i] = 1'b0; prev_rdy[i] = 1'b1; last_fall[i] = -1;
      end
    end else begin
      check_dut(0, if0.upl0, if0.upl1, if0.busy, if0.key_ready);
      check_dut(1, if1.upl0, if1.upl1, if1.busy, if1.key_ready);
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_acc(input int i, input int target, output int a);
    int n = 0;
    while (acc_cnt[i] < target && n < 1000) begin @(negedge clk); n++; end
    if (acc_cnt[i] < target) chk($sformatf("d%0d_accept_wait", i), 32'(acc_cnt[i]), 32'(target));
    a = a_edge[i];
  endtask

  task automatic send0(input logic [4:0] k, output int a);
    if0.key = k; if0.key_valid = 1'b1;
    wait_acc(0, acc_cnt[0] + 1, a);
    if0.key_valid = 1'b0; if0.key = 5'($urandom);
  endtask

  task automatic wait_frame0(input int a, output int busy_low);
    busy_low = 0;
    while (cyc < a + flen(0) + 2) begin
      @(negedge clk);
      if (cyc < a + flen(0) && if0.busy !== 1'b1) busy_low++;
    end
  endtask

  task automatic check_frame(input string tag, input int a, input logic [14:0] w);
    int n = 0, n1 = 0, prev = 0;
    int lo = a + 1;
    int hi = a + 1 + NBITS * (P0 + G0);
    foreach (rise_q[k]) begin
      if (rise_q[k] >= lo && rise_q[k] < hi) begin
        if (n == 0) chk({tag, "_first_pulse"}, 32'(rise_q[k]), 32'(lo));
        else        chk({tag, "_spacing"}, 32'(rise_q[k] - prev), 32'(P0 + G0));
        if (n < NBITS) chk({tag, "_bit"}, 32'(line_q[k]), 32'(w[NBITS-1-n]));
        if (line_q[k]) n1++;
        prev = rise_q[k];
        n++;
      end
    end
    chk({tag, "_npulse"}, 32'(n), 32'(NBITS));
    chk({tag, "_n_upl1"}, 32'(n1), 32'($countones(w)));
  endtask

  // main directed sequence on the default instance
  initial begin
    int a, a2, busy_low, r2, f2, rdy_hi;
    logic [4:0] k;
    if0.key = 5'd0; if0.key_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_upl0", 32'(if0.upl0), 32'd0);
    chk("rst_upl1", 32'(if0.upl1), 32'd0);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_key_ready", 32'(if0.key_ready), 32'd1);
    chk("rst_d1_key_ready", 32'(if1.key_ready), 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);

    send0(5'b10110, a);
    wait_frame0(a, busy_low);
    check_frame("k10110", a, 15'b10110_01001_10110);
    chk("k10110_ready_back", 32'(rdy_rise[0] - a), 32'd365);

    send0(5'b00000, a);
    wait_frame0(a, busy_low);
    check_frame("k00000", a, 15'b00000_11111_00000);
    chk("k00000_busy_hold", 32'(busy_low), 32'd0);

    // held key_valid across two frames
    if0.key = 5'b00001; if0.key_valid = 1'b1;
    wait_acc(0, acc_cnt[0] + 1, a);
    if0.key = 5'b11110;
    wait_acc(0, acc_cnt[0] + 1, a2);
    if0.key_valid = 1'b0;
    wait_frame0(a2, busy_low);
    check_frame("b2b_first", a, word_of(5'b00001));
    check_frame("b2b_second", a2, word_of(5'b11110));
    r2 = -1; f2 = -1;
    foreach (rise_q[i]) if (r2 < 0 && rise_q[i] > a + 300) begin r2 = rise_q[i]; f2 = i; end
    chk("b2b_next_pulse", 32'(r2 - a), 32'd366);
    chk("b2b_next_line", 32'((f2 >= 0) ? line_q[f2] : 1'b0), 32'd1);
    chk("b2b_frame_gap", 32'((r2 - (a + 1 + 14 * (P0 + G0) + P0)) >= G0 + W0), 32'd1);
    chk("b2b_ready_back", 32'(rdy_rise[0] - a2), 32'd365);

    // reset in the middle of bit 7
    send0(5'($urandom), a);
    wait_until(a + 1 + 7 * (P0 + G0) + 1);
    chk("pre_rst_pulse", 32'(if0.upl0 | if0.upl1), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_upl0", 32'(if0.upl0), 32'd0);
    chk("midrst_upl1", 32'(if0.upl1), 32'd0);
    chk("midrst_busy", 32'(if0.busy), 32'd0);
    chk("midrst_key_ready", 32'(if0.key_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b0;
    k = 5'($urandom);
    send0(k, a);
    wait_frame0(a, busy_low);
    check_frame("post_rst", a, word_of(k));

    // key_valid and key churn while busy
    k = 5'($urandom);
    send0(k, a);
    rdy_hi = 0;
    while (cyc < a + 360) begin
      if0.key_valid = 1'($urandom);
      if0.key = 5'($urandom);
      @(negedge clk);
      if (if0.key_ready !== 1'b0) rdy_hi++;
    end
    if0.key_valid = 1'b0;
    wait_frame0(a, busy_low);
    check_frame("churn", a, word_of(k));
    chk("churn_ready_low", 32'(rdy_hi), 32'd0);
    chk("churn_ready_back", 32'(rdy_rise[0] - a), 32'd365);

    done = 1'b1;
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // minimal-timing instance: one directed frame, then random traffic
  initial begin
    int a;
    if1.key = 5'd0; if1.key_valid = 1'b0;
    wait (rst == 1'b0);
    @(negedge clk);
    if1.key = 5'b10110; if1.key_valid = 1'b1;
    wait_acc(1, acc_cnt[1] + 1, a);
    if1.key_valid = 1'b0;
    wait_until(a + 34);
    chk("p1_ready_back", 32'(rdy_rise[1] - a), 32'd31);
    while (!done) begin
      @(negedge clk);
      if1.key_valid = ($urandom_range(0, 2) == 0);
      if1.key = 5'($urandom);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end
endmodule
